// File: rtl/mips_boot_pkg.sv
// Shared types and constants for the mips_32 boot/run sequencer.
package mips_boot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REG_INIT,
        LOAD,
        RELEASE,
        RUN,
        DONE
    } boot_state_t;

    localparam int REG_COUNT = 32;
    localparam int WORD_W    = 32;

    // Opcode of the HLT instruction; benches append it to program images.
    localparam logic [WORD_W-1:0] HALT_OPCODE = 32'hFC000000;

endpackage

// File: rtl/mips_run_watchdog.sv
// RUN-phase cycle counter with a timeout compare against MAX_RUN_CYCLES.
module mips_run_watchdog #(
    parameter int MAX_RUN_CYCLES = 1000
) (
    input  logic        clk1,
    input  logic        rst,
    input  logic        clear,
    input  logic        enable,
    output logic [31:0] count,
    output logic        expired
);

    // Count every enabled cycle; clear wins so a new boot starts from zero.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable)
            count <= count + 32'd1;
    end

    // Expires during the last permitted cycle so the FSM leaves RUN at its end.
    assign expired = enable && (count == 32'(MAX_RUN_CYCLES - 1));

endmodule

// File: rtl/mips_boot_ctrl.sv
// Boot and run sequencer for the two-phase mips_32 core: register-file
// init, program streaming into memory, PC load, release and supervision.
// Optional macro MIPS_BOOT_CHECKSUM_EN adds an XOR check of the image.
module mips_boot_ctrl
    import mips_boot_pkg::*;
#(
    parameter int          ADDR_W         = 10,
    parameter logic [31:0] RESET_PC       = 32'h0,
    parameter int          MAX_RUN_CYCLES = 1000
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [31:0]       s_data,
    input  logic              s_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              reg_we,
    output logic [4:0]        reg_addr,
    output logic [31:0]       reg_wdata,
    output logic              core_pc_load,
    output logic [31:0]       core_pc_value,
    output logic              core_run,
    input  logic              core_halted,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   words_loaded,
    output logic [31:0]       run_cycles,
    output logic              err_overflow,
    output logic              err_timeout,
    output logic              err_checksum,
    input  logic [31:0]       exp_checksum
);

    localparam int              MEM_DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W + 1)'(MEM_DEPTH - 1);

    boot_state_t state, next_state;
    logic [4:0]  init_idx;
    logic        load_end;   // final LOAD cycle: last write in flight, no more beats
    logic        beat;
    logic        start_ok;
    logic        wd_expired;

    assign start_ok = start && (state == IDLE || state == DONE);
    assign s_ready  = (state == LOAD) && !load_end;
    assign beat     = s_valid && s_ready;

    // State-decoded outputs; they follow the state register directly.
    assign busy          = (state != IDLE) && (state != DONE);
    assign done          = (state == DONE);
    assign core_run      = (state == RUN);
    assign core_pc_load  = (state == RELEASE);
    assign core_pc_value = core_pc_load ? RESET_PC : '0;
    assign reg_we        = (state == REG_INIT);
    assign reg_addr      = reg_we ? init_idx : '0;
    assign reg_wdata     = reg_we ? {27'd0, init_idx} : '0;

    mips_run_watchdog #(
        .MAX_RUN_CYCLES(MAX_RUN_CYCLES)
    ) u_wdog (
        .clk1   (clk1),
        .rst    (rst),
        .clear  (start_ok),
        .enable (core_run),
        .count  (run_cycles),
        .expired(wd_expired)
    );

    // State register.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next-state logic; an error raised during LOAD bypasses the core release.
    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: if (start) next_state = REG_INIT;
            REG_INIT:   if (init_idx == 5'(REG_COUNT - 1)) next_state = LOAD;
            LOAD:       if (load_end)
                            next_state = (err_overflow || err_checksum) ? DONE : RELEASE;
            RELEASE:    next_state = RUN;
            RUN:        if (core_halted || wd_expired) next_state = DONE;
            default:    next_state = IDLE;
        endcase
    end

    // Register-init index, memory write port, word counter and error flags.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            init_idx     <= '0;
            load_end     <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            words_loaded <= '0;
            err_overflow <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (start_ok) begin
                init_idx     <= '0;
                load_end     <= 1'b0;
                words_loaded <= '0;
                err_overflow <= 1'b0;
                err_timeout  <= 1'b0;
            end
            if (state == REG_INIT)
                init_idx <= init_idx + 5'd1;
            if (beat) begin
                mem_we       <= 1'b1;
                mem_addr     <= words_loaded[ADDR_W-1:0];
                mem_wdata    <= s_data;
                words_loaded <= words_loaded + 1'b1;
                if (s_last) begin
                    load_end <= 1'b1;
                end else if (words_loaded == LAST_ADDR) begin
                    load_end     <= 1'b1;
                    err_overflow <= 1'b1;
                end
            end
            if (core_run && wd_expired && !core_halted)
                err_timeout <= 1'b1;
        end
    end

`ifdef MIPS_BOOT_CHECKSUM_EN
    logic [WORD_W-1:0] csum;

    // Running XOR of accepted words, compared with exp_checksum on the last beat.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            csum         <= '0;
            err_checksum <= 1'b0;
        end else if (start_ok) begin
            csum         <= '0;
            err_checksum <= 1'b0;
        end else if (beat) begin
            csum <= csum ^ s_data;
            if (s_last && ((csum ^ s_data) != exp_checksum))
                err_checksum <= 1'b1;
        end
    end
`else
    logic unused_exp_checksum;
    assign unused_exp_checksum = ^exp_checksum;
    assign err_checksum        = 1'b0;
`endif

endmodule

// File: tb/tb_mips_boot_ctrl.sv
// Directed bench for mips_boot_ctrl: reset, normal boot, timeout,
// overflow, throttled stream and (when built with it) the checksum option.
module tb_mips_boot_ctrl;
    import mips_boot_pkg::*;

    localparam int AW  = 4;
    localparam int MAX = 1000;

    logic          clk1 = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [31:0]   s_data = '0;
    logic          s_last = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          reg_we;
    logic [4:0]    reg_addr;
    logic [31:0]   reg_wdata;
    logic          core_pc_load;
    logic [31:0]   core_pc_value;
    logic          core_run;
    logic          core_halted;
    logic          busy;
    logic          done;
    logic [AW:0]   words_loaded;
    logic [31:0]   run_cycles;
    logic          err_overflow;
    logic          err_timeout;
    logic          err_checksum;
    logic [31:0]   exp_checksum = '0;

    int tests = 0;
    int fails = 0;

    // Bench-side observation of DUT strobes.
    logic [31:0] reg_seen [32];
    logic [31:0] mem_img  [16];
    int reg_cnt, mem_cnt, seq_err, pc_loads, run_seen, cyc, t_start, t_run;
    logic [31:0] pc_val;
    logic halt_en = 1'b0;
    int   halt_at = 0;

    logic [31:0] img [11] = '{32'h28010009, 32'h40000008, 32'h28020005, 32'h00221820,
                              32'h0c000000, 32'h28030001, 32'hAC030004, 32'h8C040004,
                              32'h00000000, 32'h00642820, HALT_OPCODE};

    mips_boot_ctrl #(.ADDR_W(AW), .RESET_PC(32'h0), .MAX_RUN_CYCLES(MAX)) dut (
        .clk1(clk1), .rst(rst), .start(start),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .core_pc_load(core_pc_load), .core_pc_value(core_pc_value),
        .core_run(core_run), .core_halted(core_halted),
        .busy(busy), .done(done), .words_loaded(words_loaded), .run_cycles(run_cycles),
        .err_overflow(err_overflow), .err_timeout(err_timeout),
        .err_checksum(err_checksum), .exp_checksum(exp_checksum)
    );

    always #5 clk1 = ~clk1;

    // Core stand-in: raises HALTED during its halt_at-th enabled cycle.
    assign core_halted = halt_en && core_run && (run_seen == halt_at);

    // Monitor on the falling edge, away from the DUT's active edge.
    always @(negedge clk1) begin
        cyc = cyc + 1;
        if (start && t_start < 0) t_start = cyc;
        if (reg_we) begin
            reg_seen[reg_addr] = reg_wdata;
            reg_cnt = reg_cnt + 1;
        end
        if (mem_we) begin
            if (int'(mem_addr) != mem_cnt) seq_err = seq_err + 1;
            mem_img[mem_addr] = mem_wdata;
            mem_cnt = mem_cnt + 1;
        end
        if (core_pc_load) begin
            pc_loads = pc_loads + 1;
            pc_val   = core_pc_value;
            run_seen = 0;
        end
        if (core_run) begin
            if (t_run < 0) t_run = cyc;
            run_seen = run_seen + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr_mon();
        for (int i = 0; i < 32; i++) reg_seen[i] = 32'hFFFF_FFFF;
        for (int i = 0; i < 16; i++) mem_img[i] = 32'hFFFF_FFFF;
        reg_cnt = 0; mem_cnt = 0; seq_err = 0; pc_loads = 0; run_seen = 0;
        pc_val = 32'hFFFF_FFFF; t_start = -1; t_run = -1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk1); #1;
        start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d, input logic last);
        int t = 0;
        s_valid = 1'b1; s_data = d; s_last = last;
        @(negedge clk1);
        while (!s_ready && t < 200) begin
            @(negedge clk1);
            t++;
        end
        if (!s_ready) chk("send_wait", 32'(s_ready), 32'd1);
        @(posedge clk1); #1;
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int t = 0;
        while (!done && t < budget) begin
            @(negedge clk1);
            t++;
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
    endtask

    function automatic logic [31:0] xor_img(input int n);
        logic [31:0] x = '0;
        for (int i = 0; i < n; i++) x ^= img[i];
        return x;
    endfunction

    initial begin
        int ok;
        cyc = 0;
        clr_mon();

        // Reset state
        #12;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(s_ready), 0);
        chk("rst_regwe", 32'(reg_we), 0);
        chk("rst_words", 32'(words_loaded), 0);
        chk("rst_runcyc", run_cycles, 0);
        @(negedge clk1); rst = 1'b0;
        @(posedge clk1); #1;

        // Reset mid-LOAD after 3 words: strobes drop without waiting for a clock
        pulse_start();
        for (int i = 0; i < 3; i++) send_word(img[i], 1'b0);
        chk("mid_we_pre", 32'(mem_we), 1);
        rst = 1'b1; #1;
        chk("mid_we", 32'(mem_we), 0);
        chk("mid_ready", 32'(s_ready), 0);
        chk("mid_busy", 32'(busy), 0);
        chk("mid_words", 32'(words_loaded), 0);
        @(negedge clk1); rst = 1'b0;
        @(posedge clk1); #1;

        // Normal boot: 11-word image, core halts in its 40th cycle
        clr_mon();
        halt_en = 1'b1; halt_at = 40; exp_checksum = xor_img(11);
        pulse_start();
        for (int i = 0; i < 11; i++) send_word(img[i], i == 10);
        wait_done(200, "norm");
        ok = 0;
        for (int i = 0; i < 32; i++) if (reg_seen[i] == 32'(i)) ok++;
        chk("norm_regs", 32'(ok), 32);
        chk("norm_regcnt", 32'(reg_cnt), 32);
        ok = 0;
        for (int i = 0; i < 11; i++) if (mem_img[i] == img[i]) ok++;
        chk("norm_mem", 32'(ok), 11);
        chk("norm_memcnt", 32'(mem_cnt), 11);
        chk("norm_seq", 32'(seq_err), 0);
        chk("norm_pcloads", 32'(pc_loads), 1);
        chk("norm_pcval", pc_val, 0);
        chk("norm_runcyc", run_cycles, 40);
        chk("norm_words", 32'(words_loaded), 11);
        chk("norm_latency", 32'(t_run - t_start), 32'(1 + 32 + (11 + 1) + 1));
        chk("norm_errs", {29'd0, err_overflow, err_timeout, err_checksum}, 0);
        @(negedge clk1);
        chk("norm_run_off", 32'(core_run), 0);
        chk("norm_busy", 32'(busy), 0);

        // Watchdog: image never halts
        clr_mon();
        halt_en = 1'b0; exp_checksum = xor_img(3);
        pulse_start();
        for (int i = 0; i < 3; i++) send_word(img[i], i == 2);
        wait_done(MAX + 200, "wdog");
        chk("wdog_tmo", 32'(err_timeout), 1);
        chk("wdog_runseen", 32'(run_seen), 32'(MAX));
        chk("wdog_runcyc", run_cycles, 32'(MAX));
        chk("wdog_run_off", 32'(core_run), 0);
        chk("wdog_ovf", 32'(err_overflow), 0);

        // Overflow: 16-word memory, stream of 17 with s_last on the 17th
        clr_mon();
        pulse_start();
        for (int i = 0; i < 16; i++) send_word(32'h1000 + 32'(i), 1'b0);
        s_valid = 1'b1; s_data = 32'h1010; s_last = 1'b1;
        repeat (4) @(negedge clk1);
        s_valid = 1'b0; s_last = 1'b0;
        chk("ovf_done", 32'(done), 1);
        chk("ovf_flag", 32'(err_overflow), 1);
        chk("ovf_memcnt", 32'(mem_cnt), 16);
        chk("ovf_words", 32'(words_loaded), 16);
        chk("ovf_last", mem_img[15], 32'h100F);
        chk("ovf_pcload", 32'(pc_loads), 0);
        chk("ovf_run", 32'(run_seen), 0);

        // Throttled stream: s_valid toggles, s_ready must stay up in LOAD
        clr_mon();
        halt_en = 1'b1; halt_at = 5; exp_checksum = 32'h2A ^ 32'h2B ^ 32'h2C ^ 32'h2D ^ 32'h2E ^ 32'h2F;
        @(posedge clk1); #1;
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            send_word(32'h2A + 32'(i), i == 5);
            if (i < 5) begin
                @(negedge clk1);
                chk("tog_ready", 32'(s_ready), 1);
                @(posedge clk1); #1;
            end
        end
        wait_done(200, "tog");
        chk("tog_memcnt", 32'(mem_cnt), 6);
        chk("tog_seq", 32'(seq_err), 0);
        chk("tog_mem5", mem_img[5], 32'h2F);
        chk("tog_runcyc", run_cycles, 5);

`ifdef MIPS_BOOT_CHECKSUM_EN
        // Checksum off by one bit: core is never released
        clr_mon();
        exp_checksum = xor_img(11) ^ 32'h1;
        pulse_start();
        for (int i = 0; i < 11; i++) send_word(img[i], i == 10);
        wait_done(200, "csum_bad");
        chk("csum_bad_flag", 32'(err_checksum), 1);
        chk("csum_bad_run", 32'(run_seen), 0);
        chk("csum_bad_pc", 32'(pc_loads), 0);
        clr_mon();
        halt_at = 40; exp_checksum = xor_img(11);
        pulse_start();
        for (int i = 0; i < 11; i++) send_word(img[i], i == 10);
        wait_done(200, "csum_ok");
        chk("csum_ok_flag", 32'(err_checksum), 0);
        chk("csum_ok_runcyc", run_cycles, 40);
`else
        chk("csum_tied", 32'(err_checksum), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
